// File: rtl/iccm_prog_pkg.sv
// Shared state encoding and widths for the ICCM programming write buffer.
package iccm_prog_pkg;

  localparam int DataW        = 32;
  localparam int AddrWDefault = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } prog_state_e;

endpackage

// File: rtl/iccm_prog_fifo.sv
// Write-buffer FIFO between the programming controller and the ICCM write port.
// A push into a full FIFO is taken only when the head is popped in the same cycle.
module iccm_prog_fifo
  import iccm_prog_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = AddrWDefault + DataW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    wr_ptr;
  logic [PtrW:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra MSB on each pointer tells full (MSBs differ) from empty (all equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                   (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PtrW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PtrW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/iccm_prog_buffer.sv
// Buffers UART-programmed instruction words into the ICCM write port and holds
// the core in reset while an image is loading.
//
// state | meaning
// IDLE  | no session; first write starts one
// LOAD  | accepting image words
// DRAIN | image ended; committing remaining buffered words
// DONE  | image committed; done_o pulse
module iccm_prog_buffer
  import iccm_prog_pkg::*;
#(
  parameter int Depth = 4,
  parameter int AddrW = AddrWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             prog_we_i,
  input  logic [AddrW-1:0] prog_addr_i,
  input  logic [31:0]      prog_wdata_i,
  input  logic             prog_end_i,
  output logic             mem_req_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_gnt_i,
  output logic             core_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [AddrW:0]   word_cnt_o
);

  localparam logic [AddrW:0] CntMax = {1'b1, {AddrW{1'b0}}};

  prog_state_e            state_q, state_d;
  logic                   push_req;
  logic                   session_start;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   core_rst_q;
  logic                   overflow_q;
  logic [AddrW:0]         word_cnt_q;
  logic [AddrW+DataW-1:0] head;

  assign pop = !fifo_empty && mem_gnt_i;

  iccm_prog_fifo #(
    .Depth(Depth),
    .Width(AddrW + DataW)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_req),
    .pop   (pop),
    .wdata ({prog_addr_i, prog_wdata_i}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    push_req      = 1'b0;
    session_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (prog_we_i) begin
          push_req      = 1'b1;
          session_start = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        push_req = prog_we_i;
        if (prog_end_i) state_d = DRAIN;
      end
      DRAIN: begin
        push_req = prog_we_i;
        if (fifo_empty && !prog_we_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      core_rst_q <= 1'b0;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= (state_d == LOAD) || (state_d == DRAIN);
      if (session_start)
        overflow_q <= 1'b0;
      else if (push_req && fifo_full && !pop)
        overflow_q <= 1'b1;
      if (session_start)
        word_cnt_q <= '0;
      else if (pop && (word_cnt_q != CntMax))
        word_cnt_q <= word_cnt_q + (AddrW+1)'(1);
    end
  end

  // Head is masked while empty so the port idles at zero.
  assign mem_req_o   = !fifo_empty;
  assign mem_addr_o  = fifo_empty ? '0 : head[AddrW+DataW-1:DataW];
  assign mem_wdata_o = fifo_empty ? '0 : head[DataW-1:0];
  assign core_rst_o  = core_rst_q;
  assign busy_o      = (state_q == LOAD) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign overflow_o  = overflow_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_iccm_prog_buffer.sv
// Directed bench for iccm_prog_buffer: per-cycle vector table plus hand-written
// reset and counter-saturation sequences.
module tb_iccm_prog_buffer;

  localparam int AW = 12;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          prog_we_i;
  logic [AW-1:0] prog_addr_i;
  logic [31:0]   prog_wdata_i;
  logic          prog_end_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_gnt_i;
  logic          core_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;
  logic [AW:0]   word_cnt_o;

  iccm_prog_buffer #(.Depth(4), .AddrW(AW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_wdata_i (prog_wdata_i),
    .prog_end_i   (prog_end_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .core_rst_o   (core_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  // Every write the ICCM port accepts, in order.
  logic [AW+31:0] commits[$];
  always @(posedge clk_i) begin
    if (mem_req_o && mem_gnt_i) commits.push_back({mem_addr_o, mem_wdata_o});
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          pend;
    logic          gnt;
    logic          x_req;
    logic [AW-1:0] x_addr;
    logic [31:0]   x_data;
    logic          x_busy;
    logic          x_core;
    logic          x_done;
    logic          x_ovf;
    logic [AW:0]   x_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                     input logic pend, input logic gnt, input logic x_req,
                     input logic [AW-1:0] x_addr, input logic [31:0] x_data,
                     input logic x_busy, input logic x_core, input logic x_done,
                     input logic x_ovf, input logic [AW:0] x_cnt);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.pend = pend; v.gnt = gnt;
    v.x_req = x_req; v.x_addr = x_addr; v.x_data = x_data; v.x_busy = x_busy;
    v.x_core = x_core; v.x_done = x_done; v.x_ovf = x_ovf; v.x_cnt = x_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic pend, input logic gnt);
    prog_we_i    = we;
    prog_addr_i  = addr;
    prog_wdata_i = data;
    prog_end_i   = pend;
    mem_gnt_i    = gnt;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   64'(mem_req_o),   64'(0));
    check({tag, "_addr"},  64'(mem_addr_o),  64'(0));
    check({tag, "_wdata"}, 64'(mem_wdata_o), 64'(0));
    check({tag, "_core"},  64'(core_rst_o),  64'(0));
    check({tag, "_busy"},  64'(busy_o),      64'(0));
    check({tag, "_done"},  64'(done_o),      64'(0));
    check({tag, "_ovf"},   64'(overflow_o),  64'(0));
    check({tag, "_cnt"},   64'(word_cnt_o),  64'(0));
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(1));
  endtask

  initial begin
    logic [AW+31:0] exp_commits[$];

    // Two-word image, end with last write; then end pulse while idle.
    //  we addr     data           end gnt | req addr     data           bsy cor dn ovf cnt
    add(1, 12'h000, 32'h0000_0013, 0, 1,    0, 12'h000, 32'h0,         0, 0, 0, 0, 13'd0);
    add(1, 12'h001, 32'h0010_0093, 1, 1,    1, 12'h000, 32'h0000_0013, 1, 1, 0, 0, 13'd0);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h001, 32'h0010_0093, 1, 1, 0, 0, 13'd1);
    add(0, 12'h000, 32'h0,         0, 1,    0, 12'h000, 32'h0,         1, 1, 0, 0, 13'd2);
    add(0, 12'h000, 32'h0,         0, 1,    0, 12'h000, 32'h0,         0, 0, 1, 0, 13'd2);
    add(0, 12'h000, 32'h0,         1, 1,    0, 12'h000, 32'h0,         0, 0, 0, 0, 13'd2);
    add(0, 12'h000, 32'h0,         0, 0,    0, 12'h000, 32'h0,         0, 0, 0, 0, 13'd2);
    // Six writes with no grant: last two dropped, then drain four.
    add(1, 12'h010, 32'hA000_0010, 0, 0,    0, 12'h000, 32'h0,         0, 0, 0, 0, 13'd2);
    add(1, 12'h011, 32'hA000_0011, 0, 0,    1, 12'h010, 32'hA000_0010, 1, 1, 0, 0, 13'd0);
    add(1, 12'h012, 32'hA000_0012, 0, 0,    1, 12'h010, 32'hA000_0010, 1, 1, 0, 0, 13'd0);
    add(1, 12'h013, 32'hA000_0013, 0, 0,    1, 12'h010, 32'hA000_0010, 1, 1, 0, 0, 13'd0);
    add(1, 12'h014, 32'hA000_0014, 0, 0,    1, 12'h010, 32'hA000_0010, 1, 1, 0, 0, 13'd0);
    add(1, 12'h015, 32'hA000_0015, 1, 0,    1, 12'h010, 32'hA000_0010, 1, 1, 0, 1, 13'd0);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h010, 32'hA000_0010, 1, 1, 0, 1, 13'd0);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h011, 32'hA000_0011, 1, 1, 0, 1, 13'd1);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h012, 32'hA000_0012, 1, 1, 0, 1, 13'd2);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h013, 32'hA000_0013, 1, 1, 0, 1, 13'd3);
    add(0, 12'h000, 32'h0,         0, 1,    0, 12'h000, 32'h0,         1, 1, 0, 1, 13'd4);
    add(0, 12'h000, 32'h0,         0, 0,    0, 12'h000, 32'h0,         0, 0, 1, 1, 13'd4);
    add(0, 12'h000, 32'h0,         0, 0,    0, 12'h000, 32'h0,         0, 0, 0, 1, 13'd4);
    // Fill to full, then push with a simultaneous pop: no overflow, five commits.
    add(1, 12'h020, 32'hB000_0020, 0, 0,    0, 12'h000, 32'h0,         0, 0, 0, 1, 13'd4);
    add(1, 12'h021, 32'hB000_0021, 0, 0,    1, 12'h020, 32'hB000_0020, 1, 1, 0, 0, 13'd0);
    add(1, 12'h022, 32'hB000_0022, 0, 0,    1, 12'h020, 32'hB000_0020, 1, 1, 0, 0, 13'd0);
    add(1, 12'h023, 32'hB000_0023, 0, 0,    1, 12'h020, 32'hB000_0020, 1, 1, 0, 0, 13'd0);
    add(1, 12'h024, 32'hB000_0024, 1, 1,    1, 12'h020, 32'hB000_0020, 1, 1, 0, 0, 13'd0);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h021, 32'hB000_0021, 1, 1, 0, 0, 13'd1);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h022, 32'hB000_0022, 1, 1, 0, 0, 13'd2);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h023, 32'hB000_0023, 1, 1, 0, 0, 13'd3);
    add(0, 12'h000, 32'h0,         0, 1,    1, 12'h024, 32'hB000_0024, 1, 1, 0, 0, 13'd4);
    add(0, 12'h000, 32'h0,         0, 1,    0, 12'h000, 32'h0,         1, 1, 0, 0, 13'd5);
    add(0, 12'h000, 32'h0,         0, 0,    0, 12'h000, 32'h0,         0, 0, 1, 0, 13'd5);
    add(0, 12'h000, 32'h0,         0, 0,    0, 12'h000, 32'h0,         0, 0, 0, 0, 13'd5);

    exp_commits = '{{12'h000, 32'h0000_0013}, {12'h001, 32'h0010_0093},
                    {12'h010, 32'hA000_0010}, {12'h011, 32'hA000_0011},
                    {12'h012, 32'hA000_0012}, {12'h013, 32'hA000_0013},
                    {12'h020, 32'hB000_0020}, {12'h021, 32'hB000_0021},
                    {12'h022, 32'hB000_0022}, {12'h023, 32'hB000_0023},
                    {12'h024, 32'hB000_0024}};

    rst_i = 1'b1;
    drive(0, '0, '0, 0, 0);
    repeat (2) @(negedge clk_i);
    check_reset("por");
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk_i);
      check($sformatf("v%0d_req", i),  64'(mem_req_o),  64'(v.x_req));
      check($sformatf("v%0d_busy", i), 64'(busy_o),     64'(v.x_busy));
      check($sformatf("v%0d_core", i), 64'(core_rst_o), 64'(v.x_core));
      check($sformatf("v%0d_done", i), 64'(done_o),     64'(v.x_done));
      check($sformatf("v%0d_ovf", i),  64'(overflow_o), 64'(v.x_ovf));
      check($sformatf("v%0d_cnt", i),  64'(word_cnt_o), 64'(v.x_cnt));
      if (v.x_req) begin
        check($sformatf("v%0d_addr", i),  64'(mem_addr_o),  64'(v.x_addr));
        check($sformatf("v%0d_wdata", i), 64'(mem_wdata_o), 64'(v.x_data));
      end
      drive(v.we, v.addr, v.data, v.pend, v.gnt);
    end

    check("commit_count", 64'(commits.size()), 64'(exp_commits.size()));
    foreach (exp_commits[i]) begin
      if (i < commits.size())
        check($sformatf("commit%0d", i), 64'(commits[i]), 64'(exp_commits[i]));
    end

    // Reset mid-session with three words buffered.
    commits.delete();
    @(negedge clk_i); drive(1, 12'h030, 32'hC000_0030, 0, 0);
    @(negedge clk_i); drive(1, 12'h031, 32'hC000_0031, 0, 0);
    @(negedge clk_i); drive(1, 12'h032, 32'hC000_0032, 0, 0);
    @(negedge clk_i); drive(0, '0, '0, 0, 0);
    check("rst_pre_req",  64'(mem_req_o), 64'(1));
    check("rst_pre_busy", 64'(busy_o),    64'(1));
    rst_i = 1'b1;
    mem_gnt_i = 1'b1;
    #1;
    check("rst_async_req", 64'(mem_req_o), 64'(0));
    @(negedge clk_i);
    check_reset("rst_mid");
    check("rst_no_writes", 64'(commits.size()), 64'(0));
    rst_i = 1'b0;
    drive(1, 12'h040, 32'hD000_0040, 0, 1);
    @(negedge clk_i);
    check("post_rst_req",   64'(mem_req_o),   64'(1));
    check("post_rst_addr",  64'(mem_addr_o),  64'(12'h040));
    check("post_rst_wdata", 64'(mem_wdata_o), 64'(32'hD000_0040));
    check("post_rst_busy",  64'(busy_o),      64'(1));
    check("post_rst_core",  64'(core_rst_o),  64'(1));
    check("post_rst_writes", 64'(commits.size()), 64'(0));
    drive(0, '0, '0, 1, 1);
    @(negedge clk_i);
    drive(0, '0, '0, 0, 1);
    wait_done("post_rst_done");
    check("post_rst_cnt", 64'(word_cnt_o), 64'(1));
    check("post_rst_commits", 64'(commits.size()), 64'(1));
    if (commits.size() > 0)
      check("post_rst_commit0", 64'(commits[0]), 64'({12'h040, 32'hD000_0040}));

    // Stream 4097 words with continuous grant: counter must stop at 4096.
    @(negedge clk_i);
    commits.delete();
    for (int i = 0; i <= 4096; i++) begin
      @(negedge clk_i);
      drive(1, 12'(i), 32'(i), (i == 4096), 1);
    end
    @(negedge clk_i);
    drive(0, '0, '0, 0, 1);
    wait_done("sat_done");
    check("sat_cnt",     64'(word_cnt_o),     64'(4096));
    check("sat_ovf",     64'(overflow_o),     64'(0));
    check("sat_commits", 64'(commits.size()), 64'(4097));
    if (commits.size() > 0)
      check("sat_last", 64'(commits[commits.size()-1]), 64'({12'h000, 32'd4096}));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/iccm_prog_buffer.md
ICCM_PROG_BUFFER -- requirements
Module: iccm_prog_buffer

Interface
REQ-001 Parameter Depth, default 4: write-buffer entries; power of two, 2..16.
REQ-002 Parameter AddrW, default 12: ICCM word-address width.
REQ-003 clk_i  in  1  single clock for all state.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 prog_we_i  in  1  one-cycle write strobe from the UART programming controller.
REQ-006 prog_addr_i  in  AddrW  word address of the programmed word.
REQ-007 prog_wdata_i  in  32  programmed instruction word.
REQ-008 prog_end_i  in  1  end-of-image pulse from the programming controller.
REQ-009 mem_req_o  out  1  write request to the ICCM write port.
REQ-010 mem_addr_o  out  AddrW  address of the head entry.
REQ-011 mem_wdata_o  out  32  data of the head entry.
REQ-012 mem_gnt_i  in  1  ICCM accepts the write this cycle; low while a core fetch owns the port.
REQ-013 core_rst_o  out  1  hold the core in reset while an image is loading.
REQ-014 busy_o  out  1  session active (state LOAD or DRAIN).
REQ-015 done_o  out  1  one-cycle pulse when an image is fully committed.
REQ-016 overflow_o  out  1  sticky flag: a write was dropped.
REQ-017 word_cnt_o  out  AddrW+1  committed words in the current session.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, DRAIN and DONE.
REQ-019 IDLE: if prog_we_i=1, push the entry, clear word_cnt_o and overflow_o, and go to LOAD; ignore prog_end_i.
REQ-020 LOAD: push every accepted prog_we_i; if prog_end_i=1, go to DRAIN, including the same-cycle write.
REQ-021 DRAIN: keep accepting pushes; go to DONE in the first cycle the FIFO is empty and no push occurs.
REQ-022 DONE: done_o=1 for this single cycle; unconditionally go to IDLE next cycle.
REQ-023 core_rst_o SHALL be a registered output, 1 in LOAD and DRAIN and 0 in IDLE and DONE.
REQ-024 mem_req_o=1 whenever the FIFO is non-empty; mem_addr_o and mem_wdata_o are the head entry, held stable until popped.
REQ-025 A pop occurs when mem_req_o=1 and mem_gnt_i=1; the next entry presents in the following cycle.
REQ-026 Latency: a push into an empty FIFO at cycle N drives mem_req_o=1 at cycle N+1, never at N.
REQ-027 Full with no pop: prog_we_i is dropped, overflow_o is set, and the FIFO is unchanged.
REQ-028 Full with a simultaneous pop: the push is accepted and no overflow occurs.
REQ-029 word_cnt_o increments on each pop, saturates at 2^AddrW, and is cleared only at session start.
REQ-030 Pointers wrap modulo Depth; full and empty are distinguished by an extra pointer bit.
REQ-031 mem_gnt_i while mem_req_o=0 has no effect.

Reset
REQ-032 While rst_i=1, outputs SHALL be: state IDLE, FIFO empty, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=0, busy_o=0, done_o=0, overflow_o=0, word_cnt_o=0.
REQ-033 Reset asserted mid-session SHALL discard buffered entries without issuing further memory writes.
REQ-034 After reset, the block SHALL accept a new session beginning on the first cycle rst_i is low.

Structure
REQ-035 Package iccm_prog_pkg SHALL hold the state enum, the 32-bit data width constant and the AddrW default.
REQ-036 The FIFO SHALL be a separate sub-module, iccm_prog_fifo, containing storage, pointers, and full and empty flags.
REQ-037 The FSM, counter and flags SHALL reside in iccm_prog_buffer.

Verification
REQ-038 Write 0x00000013@0x000, 0x00100093@0x001, then end, with mem_gnt_i=1 -> two writes in order; done_o pulses once; word_cnt_o=2; core_rst_o returns to 0.
REQ-039 Keep mem_gnt_i=0 and push 6 writes with Depth=4 -> overflow_o=1; after grant, only the first 4 words are committed and word_cnt_o=4.
REQ-040 FIFO full, then push and grant in the same cycle -> no overflow; all 5 words commit in order.
REQ-041 Assert prog_end_i in the same cycle as the last write -> the write commits before done_o is asserted.
REQ-042 Assert rst_i with 3 entries buffered -> mem_req_o=0 next cycle; no writes follow; all outputs hold their reset values.
REQ-043 Assert prog_end_i while IDLE -> no state change; done_o stays 0.
